mod12_step_decoder: RTL and testbench
=====================================

// Module: mod12_step_decoder
// PURPOSE
//  Receive-side decoder for a mod-12 up/down count stream (values 0..11). Samples the count
//  when sample_en is high, classifies each change as up-step, down-step, hold or illegal jump,
//  and flags wrap events (11->0, 0->11). Keeps a signed net-step position and a signed
//  revolution count, and tracks lock to the stream. Sits downstream of the mod-12 counter.
// PARAMETERS
//  POS_W       16  width of signed net-step position accumulator (two's complement, wraps)
//  WRAP_W      8   width of signed revolution counter (two's complement, wraps)
//  RELOCK_CNT  4   consecutive legal non-hold steps in ERROR required to return to TRACK (>=1)
// PORTS
//  clock       in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  sync_clr    in   1       synchronous clear: state->UNSYNC, position/wrap_cnt/err_sticky->0
//  sample_en   in   1       cnt_in is valid this cycle
//  cnt_in      in   4       observed mod-12 count
//  step_up     out  1       pulse: legal +1 step accepted
//  step_dn     out  1       pulse: legal -1 step accepted
//  wrap_up     out  1       pulse: 11->0 step accepted
//  wrap_dn     out  1       pulse: 0->11 step accepted
//  hold        out  1       pulse: sample equal to previous (TRACK only)
//  jump_err    out  1       pulse: in-range sample with mod-12 delta not in {0,1,11}
//  range_err   out  1       pulse: cnt_in > 11
//  err_sticky  out  1       set by any jump_err/range_err; cleared only by sync_clr or reset
//  locked      out  1       1 when state == TRACK
//  position    out  POS_W   signed net accepted steps
//  wrap_cnt    out  WRAP_W  signed revolutions (+1 per wrap_up, -1 per wrap_dn)
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, state UNSYNC, prev=0, relock counter 0.
//  - Priority each edge: rst_n > sync_clr > sample_en. sync_clr with sample_en: sample dropped.
//  - All outputs registered; event pulses assert exactly 1 cycle after the sampling edge.
//  - cnt_in > 11 with sample_en: range_err pulse, prev unchanged, relock counter 0;
//    state UNSYNC stays UNSYNC, TRACK/ERROR -> ERROR.
//  - In-range sample: d = (cnt_in - prev) mod 12; d=0 hold, d=1 up, d=11 down, else jump.
//  - UNSYNC: first in-range sample loads prev, no event pulse, -> TRACK.
//  - TRACK: up -> step_up, position+1, and if prev==11 also wrap_up, wrap_cnt+1;
//    down -> step_dn, position-1, and if prev==0 also wrap_dn, wrap_cnt-1; hold -> hold pulse;
//    jump -> jump_err, position unchanged, relock counter 0, -> ERROR. prev<=cnt_in always.
//  - ERROR: no step/wrap/hold pulses, no accumulation; prev<=cnt_in. Legal up/down increments
//    relock counter; hold leaves it; jump -> jump_err and clears it. When counter reaches
//    RELOCK_CNT -> TRACK (completing step not accumulated), counter cleared.
//  - step_up/step_dn mutually exclusive; wrap_* only with matching step_*.
//  - position/wrap_cnt wrap silently at their widths (e.g. +max +1 -> -min).
//  - sample_en low: no state change, all pulses 0.
// STRUCTURE
//  - Shared package mod12_pkg: MOD12_MAX=4'd11, MOD12_N=12, state enum {UNSYNC, TRACK, ERROR},
//    delta-class enum {D_HOLD, D_UP, D_DN, D_JUMP, D_RANGE}.
//  - Sub-module mod12_delta_classify (combinational): prev, cnt_in -> delta class, wrap flag.
//  - Top: state register, prev register, relock counter, accumulators, registered pulses.
// TESTING
//  1. Reset; sample 0,1,...,11,0 -> 12 step_up, one wrap_up on 11->0, position=12,
//     wrap_cnt=1, locked=1 from cycle after first sample.
//  2. Sample 0,11,10 -> two step_dn, wrap_dn on 0->11 only, position=-2, wrap_cnt=-1.
//  3. TRACK at 3, sample 7 -> jump_err, locked=0, err_sticky=1; then 8,9,10,11 ->
//     locked=1 after 4th step, position unchanged across ERROR; sample 0 -> wrap_up.
//  4. TRACK at 5, sample 13 -> range_err, ERROR; 5,5,5 -> no hold pulses, counter stays 0.
//  5. POS_W=4: 8 up-steps from 0 -> position = -8 (wrap); hold sample -> hold pulse only.
//  6. rst_n low mid-stream with sample_en=1 -> outputs 0 immediately (no clock); sync_clr
//     with sample_en same cycle -> UNSYNC, sample ignored, err_sticky=0.

Source files
------------

// File: rtl/mod12_pkg.sv
// Shared types and constants for the mod-12 count-stream decoder.
package mod12_pkg;

   localparam logic [3:0] MOD12_MAX = 4'd11;
   localparam int         MOD12_N   = 12;

   typedef enum logic [1:0] {
      UNSYNC,
      TRACK,
      ERROR
   } state_e;

   typedef enum logic [2:0] {
      D_HOLD,
      D_UP,
      D_DN,
      D_JUMP,
      D_RANGE
   } delta_e;

endpackage

// File: rtl/mod12_delta_classify.sv
// Combinational classifier: mod-12 distance from the previous count to the new one,
// plus whether a legal step crosses the 11/0 boundary.
module mod12_delta_classify
   import mod12_pkg::*;
(
   input  logic [3:0] prev,
   input  logic [3:0] cnt_in,
   output delta_e     dclass,
   output logic       wrap
);

   logic [3:0] delta;

   // NOTE: every output of a combinational block gets a default first so that
   // no path through the if/case leaves it unassigned, which would infer a latch.
   always_comb begin
      dclass = D_JUMP;
      wrap   = 1'b0;
      delta  = '0;
      if (cnt_in > MOD12_MAX) begin
         dclass = D_RANGE;
      end else begin
         // prev only ever holds in-range values, so the true difference fits 4 bits
         if (cnt_in >= prev) delta = cnt_in - prev;
         else                delta = cnt_in + 4'(MOD12_N) - prev;
         case (delta)
            4'd0: dclass = D_HOLD;
            4'd1: begin
               dclass = D_UP;
               wrap   = (prev == MOD12_MAX);
            end
            MOD12_MAX: begin
               dclass = D_DN;
               wrap   = (prev == 4'd0);
            end
            default: dclass = D_JUMP;
         endcase
      end
   end

endmodule

// File: rtl/mod12_step_decoder.sv
// Receive-side decoder for a mod-12 up/down count stream: classifies sampled changes,
// accumulates net position and revolutions, and tracks lock to the stream.
module mod12_step_decoder
   import mod12_pkg::*;
#(
   parameter int POS_W      = 16,
   parameter int WRAP_W     = 8,
   parameter int RELOCK_CNT = 4
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              sync_clr,
   input  logic              sample_en,
   input  logic [3:0]        cnt_in,
   output logic              step_up,
   output logic              step_dn,
   output logic              wrap_up,
   output logic              wrap_dn,
   output logic              hold,
   output logic              jump_err,
   output logic              range_err,
   output logic              err_sticky,
   output logic              locked,
   output logic [POS_W-1:0]  position,
   output logic [WRAP_W-1:0] wrap_cnt
);

   localparam int                RC_W     = $clog2(RELOCK_CNT + 1);
   localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(RELOCK_CNT - 1);
   localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);
   localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

   state_e            state, state_nxt;
   logic [3:0]        prev, prev_nxt;
   logic [RC_W-1:0]   relock, relock_nxt;
   logic [POS_W-1:0]  pos_nxt;
   logic [WRAP_W-1:0] wrap_cnt_nxt;
   logic              sticky_nxt;
   logic              up_nxt, dn_nxt, wup_nxt, wdn_nxt, hold_nxt, jump_nxt, range_nxt;
   delta_e            dclass;
   logic              wrap;

   mod12_delta_classify u_classify (
      .prev   (prev),
      .cnt_in (cnt_in),
      .dclass (dclass),
      .wrap   (wrap)
   );

   always_comb begin
      state_nxt    = state;
      prev_nxt     = prev;
      relock_nxt   = relock;
      pos_nxt      = position;
      wrap_cnt_nxt = wrap_cnt;
      sticky_nxt   = err_sticky;
      up_nxt       = 1'b0;
      dn_nxt       = 1'b0;
      wup_nxt      = 1'b0;
      wdn_nxt      = 1'b0;
      hold_nxt     = 1'b0;
      jump_nxt     = 1'b0;
      range_nxt    = 1'b0;

      if (sync_clr) begin
         state_nxt    = UNSYNC;
         relock_nxt   = '0;
         pos_nxt      = '0;
         wrap_cnt_nxt = '0;
         sticky_nxt   = 1'b0;
      end else if (sample_en) begin
         if (dclass == D_RANGE) begin
            // out-of-range samples never disturb prev; UNSYNC has nothing to lose
            range_nxt  = 1'b1;
            sticky_nxt = 1'b1;
            relock_nxt = '0;
            if (state != UNSYNC) state_nxt = ERROR;
         end else begin
            prev_nxt = cnt_in;
            case (state)
               UNSYNC: state_nxt = TRACK;
               TRACK: begin
                  case (dclass)
                     D_UP: begin
                        up_nxt  = 1'b1;
                        pos_nxt = position + POS_ONE;
                        if (wrap) begin
                           wup_nxt      = 1'b1;
                           wrap_cnt_nxt = wrap_cnt + WRAP_ONE;
                        end
                     end
                     D_DN: begin
                        dn_nxt  = 1'b1;
                        pos_nxt = position - POS_ONE;
                        if (wrap) begin
                           wdn_nxt      = 1'b1;
                           wrap_cnt_nxt = wrap_cnt - WRAP_ONE;
                        end
                     end
                     D_HOLD: hold_nxt = 1'b1;
                     default: begin
                        jump_nxt   = 1'b1;
                        sticky_nxt = 1'b1;
                        relock_nxt = '0;
                        state_nxt  = ERROR;
                     end
                  endcase
               end
               ERROR: begin
                  case (dclass)
                     D_UP, D_DN: begin
                        // the step that completes relock is not accumulated
                        if (relock == RC_LAST) begin
                           relock_nxt = '0;
                           state_nxt  = TRACK;
                        end else begin
                           relock_nxt = relock + 1'b1;
                        end
                     end
                     D_HOLD: ;
                     default: begin
                        jump_nxt   = 1'b1;
                        sticky_nxt = 1'b1;
                        relock_nxt = '0;
                     end
                  endcase
               end
               default: state_nxt = UNSYNC;
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, regardless of statement order.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state      <= UNSYNC;
         prev       <= '0;
         relock     <= '0;
         position   <= '0;
         wrap_cnt   <= '0;
         err_sticky <= 1'b0;
         locked     <= 1'b0;
         step_up    <= 1'b0;
         step_dn    <= 1'b0;
         wrap_up    <= 1'b0;
         wrap_dn    <= 1'b0;
         hold       <= 1'b0;
         jump_err   <= 1'b0;
         range_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         prev       <= prev_nxt;
         relock     <= relock_nxt;
         position   <= pos_nxt;
         wrap_cnt   <= wrap_cnt_nxt;
         err_sticky <= sticky_nxt;
         locked     <= (state_nxt == TRACK);
         step_up    <= up_nxt;
         step_dn    <= dn_nxt;
         wrap_up    <= wup_nxt;
         wrap_dn    <= wdn_nxt;
         hold       <= hold_nxt;
         jump_err   <= jump_nxt;
         range_err  <= range_nxt;
      end
   end

endmodule

// File: tb/tb_mod12_step_decoder.sv
// Directed-vector bench for mod12_step_decoder; a second instance with POS_W=4
// shares the stimulus to exercise position wrap-around.
module tb_mod12_step_decoder;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        sync_clr = 1'b0;
   logic        sample_en = 1'b0;
   logic [3:0]  cnt_in = '0;

   logic        step_up, step_dn, wrap_up, wrap_dn, hold, jump_err, range_err;
   logic        err_sticky, locked;
   logic [15:0] position;
   logic [7:0]  wrap_cnt;

   logic        n_step_up, n_step_dn, n_wrap_up, n_wrap_dn, n_hold, n_jump, n_range;
   logic        n_sticky, n_locked;
   logic [3:0]  n_position;
   logic [7:0]  n_wrap_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int ups, dns, wups, wdns, holds;

   always #5 clock = ~clock;

   mod12_step_decoder dut (
      .clock(clock), .rst_n(rst_n), .sync_clr(sync_clr), .sample_en(sample_en),
      .cnt_in(cnt_in), .step_up(step_up), .step_dn(step_dn), .wrap_up(wrap_up),
      .wrap_dn(wrap_dn), .hold(hold), .jump_err(jump_err), .range_err(range_err),
      .err_sticky(err_sticky), .locked(locked), .position(position), .wrap_cnt(wrap_cnt)
   );

   mod12_step_decoder #(.POS_W(4)) dut_narrow (
      .clock(clock), .rst_n(rst_n), .sync_clr(sync_clr), .sample_en(sample_en),
      .cnt_in(cnt_in), .step_up(n_step_up), .step_dn(n_step_dn), .wrap_up(n_wrap_up),
      .wrap_dn(n_wrap_dn), .hold(n_hold), .jump_err(n_jump), .range_err(n_range),
      .err_sticky(n_sticky), .locked(n_locked), .position(n_position), .wrap_cnt(n_wrap_cnt)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic sample(input logic [3:0] v);
      sample_en = 1'b1;
      cnt_in    = v;
      @(posedge clock);
      #1;
      sample_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      rst_n = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
   endtask

   task automatic clr_counts();
      ups = 0; dns = 0; wups = 0; wdns = 0; holds = 0;
   endtask

   task automatic tally();
      ups   += int'(step_up);
      dns   += int'(step_dn);
      wups  += int'(wrap_up);
      wdns  += int'(wrap_dn);
      holds += int'(hold);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // reset state
      do_reset();
      check("rst_locked", locked, 0);
      check("rst_position", $signed(position), 0);
      check("rst_sticky", err_sticky, 0);

      // 1: full up revolution 0..11,0
      clr_counts();
      sample(4'd0);
      tally();
      check("t1_locked_first", locked, 1);
      check("t1_no_pulse_first", ups, 0);
      for (int i = 1; i <= 12; i++) begin
         sample(4'(i % 12));
         tally();
      end
      check("t1_step_up", ups, 12);
      check("t1_wrap_up", wups, 1);
      check("t1_position", $signed(position), 12);
      check("t1_wrap_cnt", $signed(wrap_cnt), 1);

      // 2: down steps through 0->11
      do_reset();
      clr_counts();
      sample(4'd0);
      sample(4'd11);
      check("t2_wrap_dn_first", wrap_dn, 1);
      tally();
      sample(4'd10);
      check("t2_wrap_dn_second", wrap_dn, 0);
      tally();
      check("t2_step_dn", dns, 2);
      check("t2_wrap_dn", wdns, 1);
      check("t2_position", $signed(position), -2);
      check("t2_wrap_cnt", $signed(wrap_cnt), -1);

      // 3: jump, relock after 4 legal steps, then wrap
      do_reset();
      sample(4'd3);
      sample(4'd7);
      check("t3_jump_err", jump_err, 1);
      check("t3_unlocked", locked, 0);
      check("t3_sticky", err_sticky, 1);
      sample(4'd8);
      sample(4'd9);
      sample(4'd10);
      check("t3_locked_after3", locked, 0);
      check("t3_no_step_in_error", step_up, 0);
      sample(4'd11);
      check("t3_relocked", locked, 1);
      check("t3_position_frozen", $signed(position), 0);
      sample(4'd0);
      check("t3_wrap_up", wrap_up, 1);
      check("t3_step_up", step_up, 1);
      check("t3_position_after", $signed(position), 1);
      check("t3_sticky_held", err_sticky, 1);

      // 4: range error, holds in ERROR do not advance relock
      do_reset();
      sample(4'd5);
      sample(4'd13);
      check("t4_range_err", range_err, 1);
      check("t4_unlocked", locked, 0);
      clr_counts();
      for (int i = 0; i < 3; i++) begin
         sample(4'd5);
         tally();
      end
      check("t4_no_hold", holds, 0);
      sample(4'd6);
      sample(4'd7);
      sample(4'd8);
      check("t4_still_unlocked", locked, 0);
      sample(4'd9);
      check("t4_relocked", locked, 1);

      // 5: narrow position wraps, then a hold
      do_reset();
      sample(4'd0);
      for (int i = 1; i <= 8; i++) sample(4'(i));
      check("t5_narrow_position", $signed(n_position), -8);
      check("t5_wide_position", $signed(position), 8);
      sample(4'd8);
      check("t5_hold", hold, 1);
      check("t5_hold_no_up", step_up, 0);
      check("t5_hold_no_dn", step_dn, 0);
      check("t5_hold_position", $signed(n_position), -8);

      // 6: async reset mid-stream, then sync_clr beating a sample
      do_reset();
      sample(4'd3);
      sample(4'd4);
      check("t6_pre_step_up", step_up, 1);
      sample_en = 1'b1;
      cnt_in    = 4'd5;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_step_up", step_up, 0);
      check("t6_async_position", $signed(position), 0);
      check("t6_async_locked", locked, 0);
      sample_en = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      sample(4'd3);
      sample(4'd4);
      sample(4'd9);
      check("t6_sticky_set", err_sticky, 1);
      sync_clr  = 1'b1;
      sample_en = 1'b1;
      cnt_in    = 4'd10;
      @(posedge clock);
      #1;
      sync_clr  = 1'b0;
      sample_en = 1'b0;
      check("t6_clr_locked", locked, 0);
      check("t6_clr_sticky", err_sticky, 0);
      check("t6_clr_position", $signed(position), 0);
      check("t6_clr_no_jump", jump_err, 0);
      sample(4'd5);
      check("t6_resync_locked", locked, 1);
      check("t6_resync_no_pulse", step_up, 0);
      sample(4'd6);
      check("t6_resync_step", step_up, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
